// File: rtl/rpn_stack_engine.sv
// rtl/rpn_stack_engine.sv - RPN operand stack with registered TOS, array-backed lower entries and ALU
module rpn_stack_engine #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [2:0]       cmd,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] tos,
    output logic [CW-1:0]    count,
    output logic             carry,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] TWO  = CW'(2);

    localparam logic [2:0] OP_PUSH  = 3'b000;
    localparam logic [2:0] OP_POP   = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_MUL   = 3'b100;
    localparam logic [2:0] OP_DUP   = 3'b101;
    localparam logic [2:0] OP_SWAP  = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;

    state_t             r_state;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_tos;
    logic [WIDTH-1:0]   r_old_tos;
    logic [CW-1:0]      r_count;
    logic               r_carry;
    logic               r_overflow;
    logic               r_underflow;
    logic               r_done;
    logic [WIDTH-1:0]   r_mem [DEPTH-1];
    logic [WIDTH-1:0]   r_rd_data;

    logic               w_accept;
    logic               w_spill;
    logic               w_we;
    logic [AW-1:0]      w_addr;
    logic [WIDTH-1:0]   w_wdata;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_prod;

    assign w_accept = cmd_valid && (r_state == S_IDLE);
    // PUSH/DUP push the current TOS down into the array when they succeed
    assign w_spill  = w_accept && (r_count != FULL) && (r_count != '0)
                      && ((cmd == OP_PUSH) || (cmd == OP_DUP));
    assign w_we     = w_spill || (r_state == S_WRITE);
    assign w_addr   = (r_state == S_IDLE) ? AW'(r_count - ONE) : AW'(r_count - TWO);
    assign w_wdata  = (r_state == S_WRITE) ? r_old_tos : r_tos;

    assign w_sum  = {1'b0, r_rd_data} + {1'b0, r_tos};
    assign w_diff = {1'b0, r_rd_data} - {1'b0, r_tos};
    assign w_prod = {{WIDTH{1'b0}}, r_rd_data} * {{WIDTH{1'b0}}, r_tos};

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign tos       = r_tos;
    assign count     = r_count;
    assign carry     = r_carry;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

    // Single-port array: one shared address, synchronous read, write when enabled
    always_ff @(posedge CLOCK_50) begin
        if (w_we) begin
            r_mem[w_addr] <= w_wdata;
        end
        r_rd_data <= r_mem[w_addr];
    end

    // Command FSM: accepts in idle, sequences NOS read, compute and SWAP writeback
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_op        <= OP_PUSH;
            r_tos       <= '0;
            r_old_tos   <= '0;
            r_count     <= '0;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op <= cmd;
                        case (cmd)
                            OP_PUSH: begin
                                r_done <= 1'b1;
                                if (r_count == FULL) begin
                                    r_overflow <= 1'b1;
                                end else begin
                                    r_tos   <= data_in;
                                    r_count <= r_count + ONE;
                                end
                            end
                            OP_DUP: begin
                                r_done <= 1'b1;
                                if (r_count == '0) begin
                                    r_underflow <= 1'b1;
                                end else if (r_count == FULL) begin
                                    r_overflow <= 1'b1;
                                end else begin
                                    r_count <= r_count + ONE;
                                end
                            end
                            OP_CLEAR: begin
                                r_done      <= 1'b1;
                                r_count     <= '0;
                                r_tos       <= '0;
                                r_carry     <= 1'b0;
                                r_overflow  <= 1'b0;
                                r_underflow <= 1'b0;
                            end
                            OP_POP: begin
                                if (r_count == '0) begin
                                    r_underflow <= 1'b1;
                                    r_done      <= 1'b1;
                                end else begin
                                    r_state <= S_READ;
                                end
                            end
                            default: begin
                                if (r_count < TWO) begin
                                    r_underflow <= 1'b1;
                                    r_done      <= 1'b1;
                                end else begin
                                    r_state <= S_READ;
                                end
                            end
                        endcase
                    end
                end
                S_READ: begin
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                    case (r_op)
                        OP_POP: begin
                            r_tos   <= (r_count == ONE) ? '0 : r_rd_data;
                            r_count <= r_count - ONE;
                        end
                        OP_ADD: begin
                            r_tos   <= w_sum[WIDTH-1:0];
                            r_carry <= w_sum[WIDTH];
                            r_count <= r_count - ONE;
                        end
                        OP_SUB: begin
                            r_tos   <= w_diff[WIDTH-1:0];
                            r_carry <= w_diff[WIDTH];
                            r_count <= r_count - ONE;
                        end
                        OP_MUL: begin
                            r_tos   <= w_prod[WIDTH-1:0];
                            r_carry <= (w_prod[2*WIDTH-1:WIDTH] != '0);
                            r_count <= r_count - ONE;
                        end
                        default: begin
                            r_tos     <= r_rd_data;
                            r_old_tos <= r_tos;
                            r_state   <= S_WRITE;
                            r_done    <= 1'b0;
                        end
                    endcase
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_stack_engine.sv
// tb/tb_rpn_stack_engine.sv - directed self-checking bench for rpn_stack_engine
module tb_rpn_stack_engine;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    localparam logic [2:0] OP_PUSH  = 3'b000;
    localparam logic [2:0] OP_POP   = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_MUL   = 3'b100;
    localparam logic [2:0] OP_DUP   = 3'b101;
    localparam logic [2:0] OP_SWAP  = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic [2:0]       cmd = 3'b000;
    logic [WIDTH-1:0] data_in = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] tos;
    logic [CW-1:0]    count;
    logic             carry;
    logic             overflow;
    logic             underflow;

    int checks = 0;
    int errors = 0;

    rpn_stack_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .data_in   (data_in),
        .busy      (busy),
        .done      (done),
        .tos       (tos),
        .count     (count),
        .carry     (carry),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] c, input logic [WIDTH-1:0] d);
        cmd_valid = 1'b1;
        cmd       = c;
        data_in   = d;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++; if ({busy, done, carry, overflow, underflow} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b want 00000", {busy, done, carry, overflow, underflow}); end
        checks++; if (tos !== 8'd0) begin errors++; $display("FAIL reset_tos got %0d want 0", tos); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    endtask

    task automatic test_sub();
        send(OP_PUSH, 8'd5);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL push_done got done=%b busy=%b want 1 0", done, busy); end
        checks++; if (tos !== 8'd5 || count !== 3'd1) begin errors++; $display("FAIL push_tos got tos=%0d count=%0d want 5 1", tos, count); end
        send(OP_PUSH, 8'd3);
        send(OP_SUB, 8'd0);
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL sub_n got busy=%b done=%b want 1 0", busy, done); end
        step();
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL sub_n1 got busy=%b done=%b want 1 0", busy, done); end
        step();
        checks++; if (busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL sub_n2 got busy=%b done=%b want 0 1", busy, done); end
        checks++; if (tos !== 8'd2 || count !== 3'd1 || carry !== 1'b0) begin errors++; $display("FAIL sub_result got tos=%0d count=%0d carry=%b want 2 1 0", tos, count, carry); end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL sub_done_once got %b want 0", done); end
    endtask

    task automatic test_add_mul();
        send(OP_CLEAR, 8'd0);
        send(OP_PUSH, 8'd200);
        send(OP_PUSH, 8'd100);
        send(OP_ADD, 8'd0);
        step();
        step();
        checks++; if (tos !== 8'd44 || carry !== 1'b1 || count !== 3'd1) begin errors++; $display("FAIL add_result got tos=%0d carry=%b count=%0d want 44 1 1", tos, carry, count); end
        send(OP_PUSH, 8'd16);
        send(OP_DUP, 8'd0);
        checks++; if (tos !== 8'd16 || count !== 3'd3 || busy !== 1'b0) begin errors++; $display("FAIL dup_result got tos=%0d count=%0d busy=%b want 16 3 0", tos, count, busy); end
        send(OP_MUL, 8'd0);
        step();
        step();
        checks++; if (tos !== 8'd0 || carry !== 1'b1 || count !== 3'd2) begin errors++; $display("FAIL mul_result got tos=%0d carry=%b count=%0d want 0 1 2", tos, carry, count); end
        send(OP_POP, 8'd0);
        step();
        step();
        checks++; if (tos !== 8'd44 || count !== 3'd1) begin errors++; $display("FAIL pop_after_mul got tos=%0d count=%0d want 44 1", tos, count); end
    endtask

    task automatic test_overflow();
        int busy_seen;
        busy_seen = 0;
        send(OP_CLEAR, 8'd0);
        for (int i = 1; i <= 5; i++) begin
            send(OP_PUSH, 8'(i));
            if (busy !== 1'b0) busy_seen++;
        end
        checks++; if (busy_seen !== 0) begin errors++; $display("FAIL ovf_busy got %0d busy cycles want 0", busy_seen); end
        checks++; if (count !== 3'd4 || tos !== 8'd4) begin errors++; $display("FAIL ovf_state got count=%0d tos=%0d want 4 4", count, tos); end
        checks++; if (overflow !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL ovf_flag got overflow=%b done=%b want 1 1", overflow, done); end
        send(OP_DUP, 8'd0);
        checks++; if (count !== 3'd4 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_dup got count=%0d overflow=%b want 4 1", count, overflow); end
        send(OP_CLEAR, 8'd0);
        checks++; if (count !== 3'd0 || tos !== 8'd0 || overflow !== 1'b0) begin errors++; $display("FAIL clear got count=%0d tos=%0d overflow=%b want 0 0 0", count, tos, overflow); end
    endtask

    task automatic test_underflow();
        send(OP_POP, 8'd0);
        checks++; if (underflow !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL unf_pop got underflow=%b done=%b busy=%b want 1 1 0", underflow, done, busy); end
        checks++; if (count !== 3'd0 || tos !== 8'd0) begin errors++; $display("FAIL unf_pop_state got count=%0d tos=%0d want 0 0", count, tos); end
        send(OP_PUSH, 8'd7);
        send(OP_ADD, 8'd0);
        checks++; if (underflow !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL unf_add got underflow=%b done=%b busy=%b want 1 1 0", underflow, done, busy); end
        checks++; if (tos !== 8'd7 || count !== 3'd1 || carry !== 1'b0) begin errors++; $display("FAIL unf_add_state got tos=%0d count=%0d carry=%b want 7 1 0", tos, count, carry); end
        send(OP_POP, 8'd0);
        step();
        step();
        checks++; if (tos !== 8'd0 || count !== 3'd0) begin errors++; $display("FAIL pop_last got tos=%0d count=%0d want 0 0", tos, count); end
    endtask

    task automatic test_swap();
        send(OP_CLEAR, 8'd0);
        send(OP_PUSH, 8'd1);
        send(OP_PUSH, 8'd2);
        send(OP_SWAP, 8'd0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL swap_n got busy=%b want 1", busy); end
        cmd_valid = 1'b1;
        cmd       = OP_PUSH;
        data_in   = 8'd9;
        step();
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL swap_n1 got busy=%b done=%b want 1 0", busy, done); end
        step();
        cmd_valid = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL swap_n2 got busy=%b done=%b want 1 0", busy, done); end
        step();
        checks++; if (busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL swap_n3 got busy=%b done=%b want 0 1", busy, done); end
        checks++; if (tos !== 8'd1 || count !== 3'd2) begin errors++; $display("FAIL swap_result got tos=%0d count=%0d want 1 2", tos, count); end
        step();
        checks++; if (done !== 1'b0 || count !== 3'd2) begin errors++; $display("FAIL swap_ignored got done=%b count=%0d want 0 2", done, count); end
        send(OP_POP, 8'd0);
        step();
        step();
        checks++; if (tos !== 8'd2 || count !== 3'd1) begin errors++; $display("FAIL swap_pop got tos=%0d count=%0d want 2 1", tos, count); end
    endtask

    task automatic test_reset_mid();
        send(OP_CLEAR, 8'd0);
        send(OP_PUSH, 8'd4);
        send(OP_PUSH, 8'd6);
        send(OP_MUL, 8'd0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if ({busy, done, carry, overflow, underflow} !== 5'b0 || tos !== 8'd0 || count !== 3'd0) begin errors++; $display("FAIL midreset got flags=%b tos=%0d count=%0d want 00000 0 0", {busy, done, carry, overflow, underflow}, tos, count); end
        step();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_nodone got done=%b busy=%b want 0 0", done, busy); end
        send(OP_PUSH, 8'd3);
        checks++; if (tos !== 8'd3 || count !== 3'd1) begin errors++; $display("FAIL midreset_push got tos=%0d count=%0d want 3 1", tos, count); end
    endtask

    initial begin
        test_reset();
        test_sub();
        test_add_mul();
        test_overflow();
        test_underflow();
        test_swap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rpn_stack_engine.md
Name: rpn_stack_engine

Overview:
Parametrised RPN operand stack with integrated ALU. It supersedes the single stack-pointer register with a full push/pop stack of DEPTH entries. The top-of-stack (TOS) is held in a register and the lower entries in a single-port, synchronous-read array. A command FSM sequences multi-cycle operations, reports completion, and flags overflow and underflow. It sits between the key/switch input decoder and the HEX/LEDR display logic.

Parameters:
WIDTH, 8, data width of each stack entry and ALU result
DEPTH, 8, total stack capacity including TOS (>=2); array holds DEPTH-1 entries
CW, $clog2(DEPTH+1), width of count output (derived; do not override)

Ports:
CLOCK_50  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command strobe; sampled only when busy=0
cmd  input  3  opcode: 000 PUSH, 001 POP, 010 ADD, 011 SUB, 100 MUL, 101 DUP, 110 SWAP, 111 CLEAR
data_in  input  WIDTH  operand for PUSH
busy  output  1  high while a multi-cycle command executes (state != S_IDLE)
done  output  1  one-cycle pulse on the cycle the results of a command become visible
tos  output  WIDTH  current top of stack (0 when empty)
count  output  CW  number of valid entries, 0..DEPTH
carry  output  1  ADD carry-out / SUB borrow / MUL high-half-nonzero of the last arithmetic op
overflow  output  1  sticky: PUSH or DUP attempted with count==DEPTH
underflow  output  1  sticky: operand(s) missing for POP/ADD/SUB/MUL/SWAP/DUP

Behaviour:
- Reset: all outputs 0, FSM to S_IDLE. Array contents are not cleared. Reset overrides everything, including mid-operation; the in-flight command is discarded.
- Storage: entries below TOS occupy mem[0..count-2], where mem[count-2] is next-on-stack (NOS). The array has a one-cycle read latency: an address presented at edge k yields data usable at edge k+1.
- FSM states: S_IDLE, S_READ (NOS address issued), S_EXEC (NOS data valid; compute/commit), S_WRITE (SWAP writeback).
- Acceptance: a command is accepted at the edge where cmd_valid=1 and state=S_IDLE. cmd_valid while busy is ignored (not queued).
- Single-cycle commands (stay in S_IDLE, busy stays 0). For a command accepted at edge N, results and done=1 appear after edge N:
  - PUSH: if count>0, write TOS to mem[count-1]; tos<=data_in; count+1.
  - DUP: requires count>=1; write TOS to mem[count-1]; count+1; tos unchanged.
  - CLEAR: count<=0, tos<=0, overflow<=0, underflow<=0, carry<=0.
- Two-operand ops and POP, accepted at edge N:
  - S_READ after N; S_EXEC after N+1; S_IDLE after N+2 with results committed and done=1.
  - busy is high for 2 cycles.
  - POP: tos<=NOS (or 0 if count was 1; in that case no read is needed, but timing is identical); count-1.
  - ADD: tos<=(NOS+TOS) mod 2^WIDTH; carry<=bit WIDTH of the sum.
  - SUB: tos<=(NOS-TOS) mod 2^WIDTH; carry<=borrow (NOS<TOS, unsigned).
  - MUL: tos<=low WIDTH bits of NOS*TOS; carry<=(high WIDTH bits != 0).
  - ADD/SUB/MUL: count-1.
- SWAP: S_READ, then S_EXEC (tos<=NOS, latch old TOS), then S_WRITE (old TOS written to mem[count-2]). It returns to S_IDLE after edge N+3 with done=1; busy is high for 3 cycles; count unchanged.
- Error checks are made at acceptance:
  - PUSH/DUP with count==DEPTH sets overflow.
  - POP with count==0, DUP with count==0, or ADD/SUB/MUL/SWAP with count<2 sets underflow.
  - An erroring command changes no stack state and no carry. It completes as single-cycle (done after N, busy stays 0).
- Sticky flags are cleared only by reset or CLEAR. carry changes only on successful ADD/SUB/MUL.
- done is high only for the single cycle after completion; never for ignored commands.
- No combinational path from inputs to outputs; all outputs are registered or decoded from registered state.

Test Plan:
- Reset, then PUSH 5, PUSH 3, SUB (WIDTH=8) -> after SUB accepted at edge N, busy=1 for 2 cycles, done pulse after N+2, tos=2, count=1, carry=0.
- WIDTH=8: PUSH 200, PUSH 100, ADD -> tos=44, carry=1. Then PUSH 16, DUP, MUL -> tos=0, carry=1, count=2.
- DEPTH=4: five PUSHes of 1,2,3,4,5 -> count=4, tos=4, overflow=1 after the fifth, done pulsed, busy never high. CLEAR -> count=0, tos=0, overflow=0.
- Empty stack: POP -> underflow=1, count=0, tos=0, done after 1 cycle. PUSH 7, ADD -> underflow stays 1, tos=7, count=1.
- PUSH 1, PUSH 2, SWAP -> busy 3 cycles, tos=1. POP -> tos=2, count=1. cmd_valid=1 with PUSH 9 during SWAP's busy window -> ignored, count unchanged.
- PUSH 4, PUSH 6, MUL, then assert reset at the S_EXEC cycle -> next cycle all outputs 0, busy=0, no done pulse. A subsequent PUSH 3 -> tos=3, count=1.
